// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-requester bus arbiter: state encoding,
// multiplexer select codes, hold-counter width and default hold limit.
package bus_arb_pkg;

  localparam int unsigned MAX_HOLD_DEFAULT = 8;
  // Wide enough for a hold limit of up to 255 cycles.
  localparam int unsigned HOLD_W = 8;

  localparam logic SEL_SRC0 = 1'b0;
  localparam logic SEL_SRC1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between two bus masters and the arbiter.
//   req0/req1   : level-held bus requests
//   done0/done1 : end-of-transfer pulses, meaningful only while granted
//   gnt0/gnt1   : grants
//   sel         : select for the external 2:1 bus multiplexer
//   busy        : either grant active
// slave  modport: arbiter side.  master modport: requester side.
interface bus_arbiter_if;

  logic req0;
  logic req1;
  logic done0;
  logic done1;
  logic gnt0;
  logic gnt1;
  logic sel;
  logic busy;

  modport slave (
    input  req0, req1, done0, done1,
    output gnt0, gnt1, sel, busy
  );

  modport master (
    output req0, req1, done0, done1,
    input  gnt0, gnt1, sel, busy
  );

endinterface

// File: rtl/arb_hold_counter.sv
// Counts consecutive grant cycles, saturating at MAX_HOLD-1.
//   clk, rst  : clock, async active-high reset
//   clear     : restart at 0 (has priority over enable)
//   enable    : count this cycle
//   at_max_c  : count has reached MAX_HOLD-1
module arb_hold_counter
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic at_max_c
);

  localparam logic [HOLD_W-1:0] LIMIT = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;

  // Saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (clear) begin
      hold_cnt <= '0;
    end else if (enable && (hold_cnt != LIMIT)) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  assign at_max_c = (hold_cnt == LIMIT);

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester bus arbiter with fairness on ties, a bounded hold time
// under contention and a one-cycle dead gap between owners.
//   clk, rst : clock, async active-high reset
//   bus      : slave side of bus_arbiter_if (req/done in, gnt/sel/busy out)
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  bus_arbiter_if.slave        bus
);

  arb_state_e state, state_next;
  logic gnt0, gnt0_next;
  logic gnt1, gnt1_next;
  logic busy, busy_next;
  logic sel, sel_next;
  // Requester served most recently; 1 after reset so a first tie goes to 0.
  logic last, last_next;

  logic hold_clear_c;
  logic hold_en_c;
  logic hold_max_c;

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .clk      (clk),
    .rst      (rst),
    .clear    (hold_clear_c),
    .enable   (hold_en_c),
    .at_max_c (hold_max_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
      sel   <= SEL_SRC0;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      gnt0  <= gnt0_next;
      gnt1  <= gnt1_next;
      busy  <= busy_next;
      sel   <= sel_next;
      last  <= last_next;
    end
  end

  // Arbitration, release and next-output decode.
  always_comb begin
    state_next = state;
    last_next  = last;
    sel_next   = sel;

    case (state)
      IDLE, GAP: begin
        if (bus.req0 && (!bus.req1 || last)) begin
          state_next = GNT0;
        end else if (bus.req1) begin
          state_next = GNT1;
        end else begin
          state_next = IDLE;
        end
      end
      GNT0: begin
        if (!bus.req0 || bus.done0 || (hold_max_c && bus.req1)) begin
          state_next = GAP;
          last_next  = 1'b0;
        end
      end
      GNT1: begin
        if (!bus.req1 || bus.done1 || (hold_max_c && bus.req0)) begin
          state_next = GAP;
          last_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    gnt0_next = (state_next == GNT0);
    gnt1_next = (state_next == GNT1);
    busy_next = gnt0_next | gnt1_next;

    // A grant is only ever entered from IDLE or GAP.
    hold_clear_c = (gnt0_next || gnt1_next) && (state != state_next);
    hold_en_c    = (state == GNT0) || (state == GNT1);

    if (hold_clear_c) begin
      sel_next = gnt1_next ? SEL_SRC1 : SEL_SRC0;
    end
  end

  assign bus.gnt0 = gnt0;
  assign bus.gnt1 = gnt1;
  assign bus.busy = busy;
  assign bus.sel  = sel;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, SHALL set the maximum consecutive grant cycles while the other requester waits; legal range 2..255.
REQ-002 clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req0  input  1  requester 0 bus request, level-held until served.
REQ-005 req1  input  1  requester 1 bus request, level-held until served.
REQ-006 done0  input  1  requester 0 end-of-transfer pulse; sampled only while gnt0=1.
REQ-007 done1  input  1  requester 1 end-of-transfer pulse; sampled only while gnt1=1.
REQ-008 gnt0  output  1  registered grant to requester 0.
REQ-009 gnt1  output  1  registered grant to requester 1.
REQ-010 sel  output  1  registered select for the 2:1 bus multiplexer: 0 routes source 0, 1 routes source 1.
REQ-011 busy  output  1  asserted exactly when gnt0|gnt1.

Function
REQ-012 States SHALL be IDLE, GNT0, GNT1 and GAP; gnt0=1 only in GNT0, gnt1=1 only in GNT1.
REQ-013 In IDLE and GAP: only req0 -> GNT0; only req1 -> GNT1; neither -> IDLE.
REQ-014 In IDLE and GAP with both requests, the requester not served last SHALL win: last=1 -> GNT0, last=0 -> GNT1.
REQ-015 Grant latency SHALL be one cycle: req sampled at edge N in IDLE -> gnt high from edge N+1.
REQ-016 GNTx SHALL release to GAP at the next edge when reqx=0, donex=1, or hold_cnt=MAX_HOLD-1 while the other req=1.
REQ-017 On release from GNTx, last SHALL become x.
REQ-018 GAP SHALL last exactly one cycle with both grants low, so requester ownership never changes edge-to-edge.
REQ-019 hold_cnt SHALL clear to 0 on entry to GNTx and increment each cycle in GNTx, saturating at MAX_HOLD-1.
REQ-020 Without a competing request, a grant SHALL never be force-released, regardless of hold_cnt saturation.
REQ-021 sel SHALL load 0 on entry to GNT0 and 1 on entry to GNT1, and otherwise hold its value, including through GAP and IDLE.
REQ-022 gnt0 and gnt1 SHALL never be 1 in the same cycle.
REQ-023 donex asserted while gntx=0 SHALL be ignored.
REQ-024 donex and a new reqy arriving in the same cycle SHALL give release to GAP, then arbitration in GAP per REQ-013/014.

Reset
REQ-025 When rst=1, the block SHALL immediately force state=IDLE, gnt0=0, gnt1=0, busy=0, sel=0, hold_cnt=0, last=1, independent of clk.
REQ-026 Reset asserted mid-grant SHALL drop the grant without passing through GAP.
REQ-027 After rst deasserts, the first arbitration SHALL favour req0 on a tie.

Structure
REQ-028 Package bus_arb_pkg SHALL hold the state encoding (IDLE, GNT0, GNT1, GAP), the constants SEL_SRC0=0 and SEL_SRC1=1, and the default MAX_HOLD.
REQ-029 Sub-module arb_hold_counter (clear, enable, saturate at MAX_HOLD-1, terminal flag) is the natural split; the FSM, grant registers and sel register SHALL stay in bus_arbiter.
REQ-030 The bus data multiplexer SHALL remain outside this block and be driven only by sel.

Verification
REQ-031 Reset release, then req0=req1=1 at the same edge -> gnt0=1 and sel=0 one cycle later; gnt1=0.
REQ-032 MAX_HOLD=8, req0 and req1 held high -> gnt0 high 8 cycles, 1 GAP cycle, then gnt1 high 8 cycles with sel=1, alternating thereafter.
REQ-033 req1 only, done1 pulsed on the 3rd grant cycle -> gnt1 low the next cycle, state GAP then IDLE, sel stays 1.
REQ-034 req0 alone held 20 cycles with MAX_HOLD=8 -> gnt0 continuously high for 20 cycles, no forced release.
REQ-035 rst pulsed asynchronously mid-GNT1 -> gnt1=0, sel=0 and busy=0 before the next clk edge; next tie goes to requester 0.
REQ-036 Throughout all scenarios, check every cycle that gnt0&gnt1==0, busy==gnt0|gnt1, and that done0 pulsed while gnt0=0 has no effect.
